mem_interface_unit: RTL

Memory-side responder for the instructionUnit load/store interface. It accepts load/store requests with a 14-bit address and a 16-bit ALU result, and runs byte-wide handshaked accesses to main memory. A load returns one byte on data. A store writes the result as two bytes (little-endian). Completion of every request is signalled with a one-cycle mem_done pulse.

---
 rtl/mem_interface_unit.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/mem_interface_unit.sv
// Memory-side responder for the instruction unit load/store interface.
// A load is one read beat returning a byte; a store is two little-endian write beats.
// Each beat is a req/ack handshake bounded by a timeout; every request ends with a
// one-cycle mem_done pulse, issued in the cycle after the FSM leaves its DONE state.
module mem_interface_unit #(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              store,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       result,
  output logic [7:0]        data,
  output logic              mem_done,
  output logic              busy,
  output logic              err,
  input  logic              err_clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ack
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StRd, StWrLo, StWrHi, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        result_hi_q;
  logic [CntW-1:0]   cnt_q;
  logic [7:0]        data_q;
  logic              done_q;
  logic              busy_q;
  logic              err_q;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] maddr_q;
  logic [7:0]        wdata_q;

  logic [CntW-1:0]   cnt_inc;
  logic              beat_timeout;

  // Abort a beat on the req cycle that would take the wait counter to TIMEOUT.
  always_comb begin
    cnt_inc      = cnt_q + 1'b1;
    beat_timeout = req_q && !mem_ack && (cnt_inc == CntW'(TIMEOUT));
  end

  // Transaction FSM with all outputs registered alongside the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      result_hi_q <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      maddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      done_q <= 1'b0;
      // A timeout later in this block overrides the clear.
      if (err_clr) err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (load) begin
            addr_q  <= addr;
            maddr_q <= addr;
            we_q    <= 1'b0;
            req_q   <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRd;
          end else if (store) begin
            addr_q      <= addr;
            result_hi_q <= result[15:8];
            maddr_q     <= addr;
            we_q        <= 1'b1;
            wdata_q     <= result[7:0];
            req_q       <= 1'b1;
            cnt_q       <= '0;
            busy_q      <= 1'b1;
            state_q     <= StWrLo;
          end
        end
        StRd: begin
          if (mem_ack) begin
            data_q  <= mem_rdata;
            req_q   <= 1'b0;
            state_q <= StDone;
          end else if (beat_timeout) begin
            data_q  <= 8'hFF;
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StWrLo: begin
          if (mem_ack) begin
            req_q   <= 1'b0;
            state_q <= StWrHi;
          end else if (beat_timeout) begin
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StWrHi: begin
          // First cycle here is the req gap; the high beat starts at its end.
          if (!req_q) begin
            req_q   <= 1'b1;
            maddr_q <= addr_q + ADDR_W'(1);
            wdata_q <= result_hi_q;
            cnt_q   <= '0;
          end else if (mem_ack) begin
            req_q   <= 1'b0;
            state_q <= StDone;
          end else if (beat_timeout) begin
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_inc;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign mem_done  = done_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = wdata_q;

endmodule
